dmem_mmio_responder: RTL and testbench



---
 rtl/mmio_pkg.sv | 15 +
 rtl/mmio_tx_fifo.sv | 54 +++++
 rtl/dmem_mmio_responder.sv | 115 +++++++++++
 tb/tb_dmem_mmio_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared register offsets and STATUS bit positions for the dmem MMIO responder.
package mmio_pkg;

  localparam logic [7:0] MMIO_OFS_CYCLE   = 8'h00;
  localparam logic [7:0] MMIO_OFS_TX      = 8'h01;
  localparam logic [7:0] MMIO_OFS_STATUS  = 8'h02;
  localparam logic [7:0] MMIO_OFS_SCRATCH = 8'h03;

  localparam int MMIO_ST_FULL    = 0;
  localparam int MMIO_ST_EMPTY   = 1;
  localparam int MMIO_ST_CNT_LSB = 4;
  localparam int MMIO_ST_CNT_W   = 4;
  localparam int MMIO_ST_OVF     = 8;

endpackage

// File: rtl/mmio_tx_fifo.sv
// Synchronous transmit FIFO: pushes past full and pops from empty are ignored;
// the head reads 0 while empty so the stream output never shows stale data.
module mmio_tx_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [DATA_W-1:0] head_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; the reset pointers and count already mark every entry invalid.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// MMIO responder on the dmem port: decodes a 256-word I/O window, passes the rest to dmem.
// Define MMIO_CYCLE_COUNTER_EN to build the CYCLE counter at offset 0x00.
module dmem_mmio_responder
  import mmio_pkg::*;
#(
  parameter int               ADDR_W     = 12,
  parameter int               DATA_W     = 32,
  parameter int               FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] IO_BASE   = 12'hF00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_dmem,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q_dmem,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] q_ram,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              io_hit, io_wr;
  logic [7:0]        io_ofs;
  logic              tx_push, tx_pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0] status, cycle_rd;
  logic [DATA_W-1:0] io_rdata_d, io_rdata_q, scratch_q;
  logic              io_sel_q, ovf_q;

  assign io_hit   = (address_dmem[ADDR_W-1:8] == IO_BASE[ADDR_W-1:8]);
  assign io_ofs   = address_dmem[7:0];
  assign io_wr    = wren & io_hit;
  assign ram_wren = wren & ~io_hit;

  assign tx_push   = io_wr & (io_ofs == MMIO_OFS_TX);
  assign tx_pop    = ~fifo_empty & out_ready;
  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_head;

  mmio_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (tx_push),
    .wdata_i (data),
    .pop_i   (tx_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [DATA_W-1:0] cycle_q;

  always_ff @(posedge clock) begin
    if (reset)                                  cycle_q <= '0;
    else if (io_wr && io_ofs == MMIO_OFS_CYCLE) cycle_q <= data;
    else                                        cycle_q <= cycle_q + DATA_W'(1);
  end

  assign cycle_rd = cycle_q;
`else
  assign cycle_rd = '0;
`endif

  always_comb begin
    status = '0;
    status[MMIO_ST_FULL]                           = fifo_full;
    status[MMIO_ST_EMPTY]                          = fifo_empty;
    status[MMIO_ST_CNT_LSB +: MMIO_ST_CNT_W]       = MMIO_ST_CNT_W'(fifo_count);
    status[MMIO_ST_OVF]                            = ovf_q;
  end

  // NOTE: default assignment first so every path drives io_rdata_d and no latch is inferred.
  always_comb begin
    io_rdata_d = '0;
    if (io_hit) begin
      case (io_ofs)
        MMIO_OFS_CYCLE:   io_rdata_d = cycle_rd;
        MMIO_OFS_STATUS:  io_rdata_d = status;
        MMIO_OFS_SCRATCH: io_rdata_d = scratch_q;
        default:          io_rdata_d = '0;
      endcase
    end
  end

  // NOTE: non-blocking assignments so every register samples the same pre-edge state.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_sel_q   <= 1'b0;
      io_rdata_q <= '0;
      scratch_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      io_sel_q   <= io_hit;
      io_rdata_q <= io_rdata_d;
      if (io_wr && io_ofs == MMIO_OFS_SCRATCH) scratch_q <= data;
      // A clear wins over a same-edge overflow, although the two never coincide.
      if (io_wr && io_ofs == MMIO_OFS_STATUS && data[MMIO_ST_OVF]) ovf_q <= 1'b0;
      else if (tx_push && fifo_full)                                ovf_q <= 1'b1;
    end
  end

  assign q_dmem = io_sel_q ? io_rdata_q : q_ram;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Randomized bench for dmem_mmio_responder against a queue-based register-map model,
// plus directed scenarios with hand-computed expectations.
module tb_dmem_mmio_responder;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] address = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [31:0] q_ram = '0;
  logic        out_ready = 1'b0;
  logic [31:0] q_dmem, out_data;
  logic        ram_wren, out_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  dmem_mmio_responder dut (
    .clock        (clk),
    .reset        (reset),
    .address_dmem (address),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .ram_wren     (ram_wren),
    .q_ram        (q_ram),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h, want 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_ok = 1'b0;
  logic        m_sel;
  logic [31:0] m_rdata, m_cyc, m_scr, m_rd;
  logic        m_ovf, m_hit, m_full_pre;
  logic [7:0]  m_ofs;
  logic [31:0] m_fifo[$];

  function automatic logic is_io(input logic [11:0] a);
    return a[11:8] == 4'hF;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] ofs);
    logic [3:0] cnt;
    cnt = 4'(m_fifo.size());
    case (ofs)
`ifdef MMIO_CYCLE_COUNTER_EN
      8'h00:   return m_cyc;
`endif
      8'h02:   return {23'b0, m_ovf, cnt, 2'b00, m_fifo.size() == 0, m_fifo.size() == DEPTH};
      8'h03:   return m_scr;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ok = 1'b1; m_sel = 1'b0; m_rdata = '0; m_cyc = '0; m_scr = '0; m_ovf = 1'b0;
      m_fifo.delete();
    end else if (m_ok) begin
      m_hit      = is_io(address);
      m_ofs      = address[7:0];
      m_rd       = m_hit ? m_read(m_ofs) : 32'h0;
      m_full_pre = (m_fifo.size() == DEPTH);
      if (m_fifo.size() != 0 && out_ready) void'(m_fifo.pop_front());
      if (wren && m_hit && m_ofs == 8'h01) begin
        if (m_full_pre) m_ovf = 1'b1;
        else            m_fifo.push_back(data);
      end
      if (wren && m_hit && m_ofs == 8'h02 && data[8]) m_ovf = 1'b0;
      if (wren && m_hit && m_ofs == 8'h00) m_cyc = data;
      else                                 m_cyc = m_cyc + 32'd1;
      if (wren && m_hit && m_ofs == 8'h03) m_scr = data;
      m_sel   = m_hit;
      m_rdata = m_rd;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("q_dmem",    q_dmem,         m_sel ? m_rdata : q_ram);
      check("ram_wren",  32'(ram_wren),  32'(wren && !is_io(address)));
      check("out_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
      check("out_data",  out_data,       (m_fifo.size() != 0) ? m_fifo[0] : 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [11:0] a, input logic [31:0] d, input logic w,
                       input logic rdy, input logic [31:0] qr);
    address   = a;
    data      = d;
    wren      = w;
    out_ready = rdy;
    q_ram     = qr;
  endtask

  logic [31:0] exp_cyc;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // RAM pass-through after reset
    drive(12'h005, 32'h0, 1'b0, 1'b0, 32'h1234);
    tick();
    check("ram_read", q_dmem, 32'h1234);
    drive(12'h005, 32'h55, 1'b1, 1'b0, 32'h1234);
    #1 check("ram_wren_pass", 32'(ram_wren), 32'h1);
    tick();

    // SCRATCH write and readback
    drive(12'hF03, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    #1 check("io_wren_blocked", 32'(ram_wren), 32'h0);
    tick();
    drive(12'hF03, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    check("scratch_rd", q_dmem, 32'hDEADBEEF);

    // Fill past full, then drain
    for (int i = 1; i <= 9; i++) begin
      drive(12'hF01, 32'(i), 1'b1, 1'b0, 32'h0);
      tick();
    end
    drive(12'hF02, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    check("status_full_ovf", q_dmem, 32'h181);
    for (int i = 1; i <= 8; i++) begin
      drive(12'h010, 32'h0, 1'b0, 1'b1, 32'h0);
      check("drain_valid", 32'(out_valid), 32'h1);
      check("drain_data", out_data, 32'(i));
      tick();
    end
    check("drained_valid", 32'(out_valid), 32'h0);
    drive(12'hF02, 32'h100, 1'b1, 1'b0, 32'h0);
    tick();
    drive(12'hF02, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    check("status_cleared", q_dmem, 32'h002);

    // Simultaneous push and pop at count 3
    for (int i = 1; i <= 3; i++) begin
      drive(12'hF01, 32'hA0 + 32'(i), 1'b1, 1'b0, 32'h0);
      tick();
    end
    drive(12'hF01, 32'hA4, 1'b1, 1'b1, 32'h0);
    check("pushpop_head", out_data, 32'hA1);
    tick();
    drive(12'hF02, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    check("pushpop_count", q_dmem, 32'h030);
    check("pushpop_next", out_data, 32'hA2);

    // CYCLE wrap: loaded 0xFFFFFFFE, read sampled four edges later sees 1
    drive(12'hF00, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0);
    tick();
    repeat (3) begin
      drive(12'h010, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
    end
    drive(12'hF00, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
`ifdef MMIO_CYCLE_COUNTER_EN
    exp_cyc = 32'h1;
`else
    exp_cyc = 32'h0;
`endif
    check("cycle_wrap", q_dmem, exp_cyc);

    // Reset with five entries queued
    for (int i = 1; i <= 2; i++) begin
      drive(12'hF01, 32'hB0 + 32'(i), 1'b1, 1'b0, 32'h0);
      tick();
    end
    reset = 1'b1;
    drive(12'h010, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", out_data, 32'h0);
    drive(12'hF02, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    check("rst_status", q_dmem, 32'h002);
    drive(12'hF03, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    check("rst_scratch", q_dmem, 32'h0);

    // Randomized traffic with varying consumer back-pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 600; n++) begin
        int unsigned sel;
        logic [11:0] a;
        logic [31:0] d;
        sel = $urandom_range(0, 9);
        if (sel <= 5)      a = 12'hF00 + 12'(sel);
        else if (sel == 6) a = {4'hF, 8'($urandom)};
        else               a = 12'($urandom);
        d = $urandom;
        drive(a, d, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 99) < ph * 30), $urandom);
        reset = ($urandom_range(0, 299) == 0);
        tick();
      end
    end
    reset = 1'b0;
    drive(12'h010, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
